// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-ported memory,
// with anti-starvation for the fetch port and a BUSY timeout that aborts stuck accesses.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        i_done,
   output logic        d_done,
   output logic        i_err,
   output logic        d_err,
   output logic [31:0] i_rdata,
   output logic [31:0] d_rdata,
   output logic        stall_if,
   output logic        stall_mem
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE    = TW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [SW-1:0] starve_cnt, starve_nx;
   logic [TW-1:0] tmo_cnt, tmo_nx;
   logic          abort, abort_nx;
   logic          owner_d, owner_nx;
   logic          we, we_nx;
   logic [31:0]   addr, addr_nx;
   logic [31:0]   wdata, wdata_nx;
   logic [31:0]   i_rdata_nx, d_rdata_nx;
   logic          i_done_nx, d_done_nx, i_err_nx, d_err_nx;
   logic          pick_d;

   assign mem_addr  = addr;
   assign mem_wdata = wdata;
   assign stall_if  = i_req & ~i_done & ~i_err;
   assign stall_mem = d_req & ~d_done & ~d_err;

   // Next-state, arbitration and completion logic; done/err are set on entry to RESP
   always_comb begin
      state_nx   = state;
      starve_nx  = starve_cnt;
      tmo_nx     = tmo_cnt;
      abort_nx   = abort;
      owner_nx   = owner_d;
      we_nx      = we;
      addr_nx    = addr;
      wdata_nx   = wdata;
      i_rdata_nx = i_rdata;
      d_rdata_nx = d_rdata;
      i_done_nx  = 1'b0;
      d_done_nx  = 1'b0;
      i_err_nx   = 1'b0;
      d_err_nx   = 1'b0;
      pick_d     = 1'b0;
      case (state)
         IDLE: begin
            if (i_req | d_req) begin
               pick_d   = d_req & (~i_req | (starve_cnt != STARVE_MAX));
               owner_nx = pick_d;
               state_nx = BUSY;
               if (pick_d) begin
                  addr_nx  = d_addr;
                  we_nx    = d_we;
                  wdata_nx = d_wdata;
                  if (i_req) begin
                     starve_nx = starve_cnt + STARVE_ONE;
                  end else begin
                     starve_nx = starve_cnt;
                  end
               end else begin
                  addr_nx   = i_addr;
                  we_nx     = 1'b0;
                  wdata_nx  = 32'h0000_0000;
                  starve_nx = {SW{1'b0}};
               end
            end else begin
               state_nx = IDLE;
            end
         end
         BUSY: begin
            tmo_nx = tmo_cnt + TMO_ONE;
            if (mem_ack) begin
               state_nx  = RESP;
               abort_nx  = 1'b0;
               d_done_nx = owner_d;
               i_done_nx = ~owner_d;
               if (~we & owner_d) begin
                  d_rdata_nx = mem_rdata;
               end else if (~we) begin
                  i_rdata_nx = mem_rdata;
               end else begin
                  d_rdata_nx = d_rdata;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               state_nx = RESP;
               abort_nx = 1'b1;
               d_err_nx = owner_d;
               i_err_nx = ~owner_d;
            end else begin
               state_nx = BUSY;
            end
         end
         RESP: begin
            state_nx = IDLE;
            tmo_nx   = {TW{1'b0}};
            abort_nx = 1'b0;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers; memory strobes follow the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= {SW{1'b0}};
         tmo_cnt    <= {TW{1'b0}};
         abort      <= 1'b0;
         owner_d    <= 1'b0;
         we         <= 1'b0;
         addr       <= 32'h0000_0000;
         wdata      <= 32'h0000_0000;
         i_rdata    <= 32'h0000_0000;
         d_rdata    <= 32'h0000_0000;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         i_err      <= 1'b0;
         d_err      <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
      end else begin
         state      <= state_nx;
         starve_cnt <= starve_nx;
         tmo_cnt    <= tmo_nx;
         abort      <= abort_nx;
         owner_d    <= owner_nx;
         we         <= we_nx;
         addr       <= addr_nx;
         wdata      <= wdata_nx;
         i_rdata    <= i_rdata_nx;
         d_rdata    <= d_rdata_nx;
         i_done     <= i_done_nx;
         d_done     <= d_done_nx;
         i_err      <= i_err_nx;
         d_err      <= d_err_nx;
         mem_req    <= (state_nx == BUSY);
         mem_we     <= (state_nx == BUSY) & we_nx;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT      = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, mem_ack;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        mem_req, mem_we, i_done, d_done, i_err, d_err, stall_if, stall_mem;
   logic [31:0] mem_addr, mem_wdata, i_rdata, d_rdata;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          starve   = 0;
   logic [31:0] m_i_rdata = 32'h0;
   logic [31:0] m_d_rdata = 32'h0;

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .i_done(i_done), .d_done(d_done), .i_err(i_err), .d_err(d_err),
      .i_rdata(i_rdata), .d_rdata(d_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet_outputs(input string tag);
      chk({tag, "_mem_req"}, mem_req, 1'b0);
      chk({tag, "_mem_we"}, mem_we, 1'b0);
      chk({tag, "_pulses"}, {i_done, d_done, i_err, d_err}, 4'b0000);
      chk({tag, "_i_rdata"}, i_rdata, m_i_rdata);
      chk({tag, "_d_rdata"}, d_rdata, m_d_rdata);
   endtask

   // One access: predicts the winner, acks at BUSY cycle lat (none if lat >= TIMEOUT),
   // checks completion, then releases the owner's request.
   task automatic txn(input int lat, input logic [31:0] rd, input bit drop_early, output bit owner_d);
      bit          exp_d, acked;
      int          k, busy;
      logic [31:0] exp_addr, exp_wdata;
      logic        exp_we;
      exp_d = d_req && (!i_req || starve != STARVE_LIMIT);
      if (exp_d && i_req) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
      else if (!exp_d) starve = 0;
      exp_addr  = exp_d ? d_addr : i_addr;
      exp_we    = exp_d ? d_we : 1'b0;
      exp_wdata = exp_d ? d_wdata : 32'h0;
      owner_d   = exp_d;
      k = 0;
      while (mem_req !== 1'b1 && k < 6) begin
         step();
         k++;
      end
      chk("grant_seen", mem_req, 1'b1);
      chk("grant_addr", mem_addr, exp_addr);
      chk("grant_we", mem_we, exp_we);
      chk("grant_wdata", mem_wdata, exp_wdata);
      if (drop_early) begin
         if (exp_d) d_req = 1'b0;
         else i_req = 1'b0;
      end
      acked = 1'b0;
      busy  = 0;
      for (int c = 0; c < TIMEOUT; c++) begin
         if (mem_req === 1'b1 && mem_addr === exp_addr && mem_we === exp_we) busy++;
         if (c == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
            acked     = 1'b1;
         end
         step();
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (acked) break;
      end
      chk("busy_cycles", busy, acked ? lat + 1 : TIMEOUT);
      chk("resp_mem_req", mem_req, 1'b0);
      chk("i_done", i_done, !exp_d && acked);
      chk("d_done", d_done, exp_d && acked);
      chk("i_err", i_err, !exp_d && !acked);
      chk("d_err", d_err, exp_d && !acked);
      if (acked && !exp_we) begin
         if (exp_d) m_d_rdata = rd;
         else m_i_rdata = rd;
      end
      chk("resp_i_rdata", i_rdata, m_i_rdata);
      chk("resp_d_rdata", d_rdata, m_d_rdata);
      if (exp_d) chk("stall_mem_resp", stall_mem, 1'b0);
      else chk("stall_if_resp", stall_if, 1'b0);
      if (exp_d) d_req = 1'b0;
      else i_req = 1'b0;
      mem_ack   = $urandom_range(0, 1);
      mem_rdata = $urandom;
      step();
      mem_ack = 1'b0;
      chk_quiet_outputs("idle");
      chk("idle_addr_hold", mem_addr, exp_addr);
   endtask

   initial begin
      bit own;
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
      step();
      step();
      chk_quiet_outputs("reset");
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      rst = 1'b0;
      step();

      // Single instruction read
      i_req = 1'b1; i_addr = 32'h0000_0100;
      txn(3, 32'hDEAD_BEEF, 1'b0, own);
      chk("single_read_rdata", i_rdata, 32'hDEAD_BEEF);
      chk("single_read_stall", stall_if, 1'b0);

      // Sustained contention with 1-cycle ack
      i_req = 1'b1; i_addr = $urandom;
      d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; d_wdata = $urandom;
      for (int k = 0; k < 10; k++) begin
         txn(0, $urandom, 1'b0, own);
         chk("grant_order", own, (k % 5 == 4) ? 1'b0 : 1'b1);
         if (own) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = $urandom;
         end else begin
            i_req = 1'b1; i_addr = $urandom;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      step();
      step();

      // Data write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
      txn(1, 32'hCAFE_F00D, 1'b0, own);
      chk("write_d_rdata", d_rdata, m_d_rdata);

      // Timeout on a data read
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h0;
      txn(TIMEOUT + 5, 32'h0, 1'b0, own);

      // Spurious ack while idle
      mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
      step();
      step();
      mem_ack = 1'b0;
      chk_quiet_outputs("spurious");

      // Reset in the second BUSY cycle, then a stale ack
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      step();
      chk("rst_test_grant", mem_req, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_2222; d_req = 1'b0;
      starve = 0; m_i_rdata = 32'h0; m_d_rdata = 32'h0;
      chk_quiet_outputs("mid_reset");
      chk("mid_reset_addr", mem_addr, 32'h0);
      step();
      mem_ack = 1'b0;
      chk_quiet_outputs("stale_ack");

      // Randomized traffic
      for (int it = 0; it < 80; it++) begin
         if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req = 1'b1; i_addr = $urandom;
         end
         if (!d_req && (!i_req || $urandom_range(0, 1) == 1)) begin
            d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
         end
         txn($urandom_range(0, TIMEOUT + 3), $urandom, $urandom_range(0, 7) == 0, own);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data-port wins under contention before the instruction port is forced to win.
REQ-002 Parameter TIMEOUT, default 16: BUSY cycles without mem_ack before the access is aborted.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  instruction-fetch read request; level, held until i_done or i_err.
REQ-006 i_addr  input  32  instruction fetch address, stable while i_req is high.
REQ-007 d_req  input  1  data-stage request; level, held until d_done or d_err.
REQ-008 d_we  input  1  data request is a write (1) or a read (0).
REQ-009 d_addr  input  32  data address, stable while d_req is high.
REQ-010 d_wdata  input  32  data write value, stable while d_req is high.
REQ-011 mem_req  output  1  access strobe to the shared single-ported memory.
REQ-012 mem_we  output  1  write enable to memory.
REQ-013 mem_addr  output  32  memory address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
REQ-016 mem_rdata  input  32  memory read data.
REQ-017 i_done, d_done  output  1 each  one-cycle completion pulse to the owning port.
REQ-018 i_err, d_err  output  1 each  one-cycle timeout pulse to the owning port.
REQ-019 i_rdata, d_rdata  output  32 each  registered read data, updated only by a successful read.
REQ-020 stall_if, stall_mem  output  1 each  stall_if = i_req & ~i_done & ~i_err; stall_mem = d_req & ~d_done & ~d_err.

Function
REQ-021 FSM states: IDLE, BUSY, RESP; reset state IDLE.
REQ-022 IDLE, no request: stay in IDLE; mem_req=0.
REQ-023 IDLE, at least one request: choose a winner, latch its address, we and wdata (we=0, wdata=0 for the instruction port) plus the owner, then go to BUSY.
REQ-024 Winner when only one port requests: that port.
REQ-025 Winner when both request: the data port, unless starve_cnt==STARVE_LIMIT, in which case the instruction port.
REQ-026 starve_cnt update: +1 (saturating at STARVE_LIMIT) when both request and the data port wins; cleared whenever the instruction port wins; unchanged otherwise.
REQ-027 BUSY: mem_req=1; mem_we, mem_addr and mem_wdata come from the latched values and are stable for the whole state; tmo_cnt increments each cycle.
REQ-028 BUSY with mem_ack=1: go to RESP. On a read, also capture mem_rdata into the owner's rdata register.
REQ-029 BUSY, mem_ack=0 and tmo_cnt==TIMEOUT-1: go to RESP with an abort flag set; rdata is left unchanged.
REQ-030 RESP: pulse the owner's done (or err if aborted) for exactly one cycle, clear tmo_cnt and the abort flag, then return to IDLE; no arbitration in RESP.
REQ-031 A completed write pulses done and leaves rdata unchanged.
REQ-032 Minimum latency: request seen in IDLE at cycle N, mem_ack at N+1, done at N+2. Back-to-back service reaches IDLE at N+3.
REQ-033 mem_ack in IDLE or RESP is ignored and changes no state or output.
REQ-034 Outside BUSY: mem_req=0, mem_we=0; mem_addr and mem_wdata hold their last value.
REQ-035 A requester that drops req while it owns BUSY does not abort the access; done still pulses.

Reset
REQ-036 rst=1 forces on the next edge: state=IDLE, starve_cnt=0, tmo_cnt=0, abort=0, owner=instruction port, latched address/data=0, i_rdata=d_rdata=0, all done/err=0, mem_req=mem_we=0.
REQ-037 Reset during BUSY drops mem_req on the next edge with no done or err pulse. A later stale mem_ack is ignored.

Verification
REQ-038 Single read: i_req, i_addr=0x100; mem_ack 3 cycles into BUSY with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; i_done pulses once; i_rdata=0xDEADBEEF; stall_if low after the pulse.
REQ-039 Contention: both ports requesting continuously, 1-cycle ack -> grant order D,D,D,D,I,D,D,D,D,I...; starve_cnt clears after each instruction grant.
REQ-040 Write: d_req, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_we=1 with those values during BUSY; d_done pulses; d_rdata unchanged.
REQ-041 Timeout: d_req, mem_ack never asserted -> mem_req high exactly 16 cycles; d_err pulses once; no d_done; FSM returns to IDLE.
REQ-042 Reset mid-access: rst in the 2nd BUSY cycle, then mem_ack 1 cycle later -> mem_req=0 after the edge; no done or err; all outputs at reset values.
REQ-043 Spurious ack: mem_ack=1 in IDLE with no requests -> no state change; rdata registers unchanged.
